// File: rtl/run_decoding_pkg.sv
// Shared CAVLC run-decoding definitions: widths, FSM state codes and small helpers.
package run_decoding_pkg;

  localparam int LW = 16;  // level / coefficient width
  localparam int NC = 16;  // coefficient slots per block

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef logic [NC-1:0][LW-1:0] coeff_arr_t;

  // Scan position of the first (highest-frequency) level; wraps harmlessly when tc == 0.
  function automatic logic [4:0] start_pos(input logic [4:0] tc, input logic [3:0] tz);
    return tc - 5'd1 + {1'b0, tz};
  endfunction

endpackage

// File: rtl/run_decoding_if.sv
// Block-level handshake and data bus between level decoding, the bitstream buffer and run decoding.
interface run_decoding_if;
  import run_decoding_pkg::*;

  logic                start;
  logic [4:0]          TotalCoeff;
  logic [3:0]          total_zeros;
  logic [4:0]          maxNumCoeff;
  logic [NC*LW-1:0]    level_bus;
  logic [15:0]         BitStream_buffer_output;
  logic [3:0]          run_before_len;
  logic [NC*LW-1:0]    coeff_bus;
  logic                busy;
  logic                done;
  logic                run_error;

  modport master (
    output start, TotalCoeff, total_zeros, maxNumCoeff, level_bus, BitStream_buffer_output,
    input  run_before_len, coeff_bus, busy, done, run_error
  );

  modport slave (
    input  start, TotalCoeff, total_zeros, maxNumCoeff, level_bus, BitStream_buffer_output,
    output run_before_len, coeff_bus, busy, done, run_error
  );

endinterface

// File: rtl/run_decoding_run_before_lut.sv
// Combinational run_before codeword decoder: (zerosLeft, next 11 bits MSB-first) -> run, length.
module run_before_lut (
  input  logic [3:0]  zeros_left_i,
  input  logic [10:0] bits_i,
  output logic [3:0]  run_o,
  output logic [3:0]  len_o,
  output logic        valid_o
);

  logic found;

  always_comb begin
    // NOTE: every output gets a default first so no branch can leave one unassigned (no latches).
    run_o   = '0;
    len_o   = '0;
    valid_o = 1'b1;
    found   = 1'b0;
    case (zeros_left_i)
      4'd0: valid_o = 1'b0;
      4'd1: begin
        len_o = 4'd1;
        run_o = bits_i[10] ? 4'd0 : 4'd1;
      end
      4'd2: begin
        if (bits_i[10]) begin
          len_o = 4'd1;
          run_o = 4'd0;
        end else begin
          len_o = 4'd2;
          run_o = bits_i[9] ? 4'd1 : 4'd2;
        end
      end
      4'd3: begin
        len_o = 4'd2;
        run_o = 4'd3 - {2'b00, bits_i[10:9]};
      end
      4'd4: begin
        if (bits_i[10] || bits_i[9]) begin
          len_o = 4'd2;
          run_o = 4'd3 - {2'b00, bits_i[10:9]};
        end else begin
          len_o = 4'd3;
          run_o = bits_i[8] ? 4'd3 : 4'd4;
        end
      end
      4'd5: begin
        if (bits_i[10]) begin
          len_o = 4'd2;
          run_o = bits_i[9] ? 4'd0 : 4'd1;
        end else begin
          len_o = 4'd3;
          run_o = 4'd5 - {2'b00, bits_i[9:8]};
        end
      end
      4'd6: begin
        if (bits_i[10:9] == 2'b11) begin
          len_o = 4'd2;
          run_o = 4'd0;
        end else begin
          len_o = 4'd3;
          case (bits_i[10:8])
            3'b000:  run_o = 4'd1;
            3'b001:  run_o = 4'd2;
            3'b011:  run_o = 4'd3;
            3'b010:  run_o = 4'd4;
            3'b101:  run_o = 4'd5;
            default: run_o = 4'd6;  // 100
          endcase
        end
      end
      default: begin
        if (bits_i[10:8] != 3'b000) begin
          len_o = 4'd3;
          run_o = 4'd7 - {1'b0, bits_i[10:8]};
        end else begin
          // Escape codes: three leading zeros plus k more, then a 1, give run 7+k.
          for (int k = 0; k < 8; k++) begin
            if (!found && bits_i[7-k]) begin
              found = 1'b1;
              run_o = 4'(k + 7);
              len_o = 4'(k + 4);
            end
          end
          valid_o = found;
        end
      end
    endcase
  end

endmodule

// File: rtl/run_decoding.sv
// CAVLC run_before decoding: places one level per cycle into the scan-ordered coefficient array.
module run_decoding
  import run_decoding_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  run_decoding_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic [4:0] i_q, i_d;
  logic [4:0] pos_q, pos_d;
  logic [3:0] zl_q, zl_d;
  logic [4:0] tc_q, tc_d;
  logic       err_q, err_d;
  coeff_arr_t coeff_q, coeff_d;
  coeff_arr_t level_arr;

  logic [3:0] lut_run, lut_len, run_eff;
  logic       lut_valid, decode_en, last_level, run_bad, over;
  logic       unused_bits;

  assign level_arr   = bus.level_bus;
  assign unused_bits = ^bus.BitStream_buffer_output[4:0];

  run_before_lut u_lut (
    .zeros_left_i (zl_q),
    .bits_i       (bus.BitStream_buffer_output[15:5]),
    .run_o        (lut_run),
    .len_o        (lut_len),
    .valid_o      (lut_valid)
  );

  // The last level's run is implicit (all remaining zeros), so it never reads bits.
  assign decode_en  = (state_q == ST_RUN) && ((i_q + 5'd1) < tc_q) && (zl_q != 4'd0);
  assign last_level = (i_q + 5'd1) == tc_q;
  assign run_bad    = !lut_valid || (lut_run > zl_q);
  assign run_eff    = run_bad ? zl_q : lut_run;
  assign over       = ({1'b0, bus.TotalCoeff} + {2'b00, bus.total_zeros}) > {1'b0, bus.maxNumCoeff};

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pos_d   = pos_q;
    zl_d    = zl_q;
    tc_d    = tc_q;
    err_d   = err_q;
    coeff_d = coeff_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          coeff_d = '0;
          i_d     = '0;
          zl_d    = bus.total_zeros;
          pos_d   = start_pos(bus.TotalCoeff, bus.total_zeros);
          err_d   = over;
          tc_d    = over ? 5'd0 : bus.TotalCoeff;
          state_d = (over || bus.TotalCoeff == 5'd0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        coeff_d[pos_q[3:0]] = level_arr[i_q[3:0]];
        i_d = i_q + 5'd1;
        if (decode_en) begin
          pos_d = pos_q - {1'b0, run_eff} - 5'd1;
          zl_d  = zl_q - run_eff;
          if (run_bad) err_d = 1'b1;
        end else begin
          pos_d = pos_q - 5'd1;
        end
        if (last_level) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      pos_q   <= '0;
      zl_q    <= '0;
      tc_q    <= '0;
      err_q   <= 1'b0;
      // NOTE: the coefficient file is reset too, since coeff_bus must read zero straight out of reset.
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pos_q   <= pos_d;
      zl_q    <= zl_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      coeff_q <= coeff_d;
    end
  end

  assign bus.run_before_len = (decode_en && lut_valid) ? lut_len : 4'd0;
  assign bus.coeff_bus      = coeff_q;
  assign bus.busy           = (state_q == ST_RUN);
  assign bus.done           = (state_q == ST_FIN);
  assign bus.run_error      = err_q;

endmodule
